// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: turns UART byte frames into 8-bit register bus strobes.
// Frames are 'W' addr data (write, answered with ACK_BYTE) and 'R' addr
// (read, answered with the register value). Unknown opcodes get NAK_BYTE.
// Each command produces exactly one response byte on the transmit side.
module uart_reg_bridge #(
    parameter int unsigned TIMEOUT  = 100000,
    parameter logic [7:0]  ACK_BYTE = 8'h4B,
    parameter logic [7:0]  NAK_BYTE = 8'h3F
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata
);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam int         CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        WRITE,
        READ,
        READ_CAP,
        SEND,
        TX_WAIT_HI,
        TX_WAIT_LO
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_is_write;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_tx_data;
    logic [7:0]    r_reg_addr;
    logic [7:0]    r_reg_wdata;

    logic          w_timeout;
    logic          w_in_frame;
    logic          w_load_op;
    logic          w_op_write;
    logic          w_load_addr;
    logic          w_load_wdata;
    logic          w_load_tx;
    logic [7:0]    w_tx_val;
    logic          w_tx_start;
    logic          w_reg_we;
    logic          w_reg_re;

    assign w_in_frame = (r_state == GET_ADDR) || (r_state == GET_DATA);
    assign w_timeout  = (r_cnt == TO_VAL);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state decode and single-cycle strobes.
    // NOTE: every signal gets a default before the case; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_load_op    = 1'b0;
        w_op_write   = 1'b0;
        w_load_addr  = 1'b0;
        w_load_wdata = 1'b0;
        w_load_tx    = 1'b0;
        w_tx_val     = 8'h00;
        w_tx_start   = 1'b0;
        w_reg_we     = 1'b0;
        w_reg_re     = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                        w_load_op    = 1'b1;
                        w_op_write   = (rx_data == OP_WRITE);
                        w_next_state = GET_ADDR;
                    end else begin
                        w_load_tx    = 1'b1;
                        w_tx_val     = NAK_BYTE;
                        w_next_state = SEND;
                    end
                end
            end
            GET_ADDR: begin
                // A byte arriving on the expiry cycle still wins.
                if (rx_valid) begin
                    w_load_addr  = 1'b1;
                    w_next_state = r_is_write ? GET_DATA : READ;
                end else if (w_timeout) begin
                    w_next_state = IDLE;
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
                    w_load_wdata = 1'b1;
                    w_next_state = WRITE;
                end else if (w_timeout) begin
                    w_next_state = IDLE;
                end
            end
            WRITE: begin
                w_reg_we     = 1'b1;
                w_load_tx    = 1'b1;
                w_tx_val     = ACK_BYTE;
                w_next_state = SEND;
            end
            READ: begin
                w_reg_re     = 1'b1;
                w_next_state = READ_CAP;
            end
            READ_CAP: begin
                // Bus returns data the cycle after the read strobe.
                w_load_tx    = 1'b1;
                w_tx_val     = reg_rdata;
                w_next_state = SEND;
            end
            SEND: begin
                if (!tx_busy) begin
                    w_tx_start   = 1'b1;
                    w_next_state = TX_WAIT_HI;
                end
            end
            TX_WAIT_HI: begin
                if (tx_busy) w_next_state = TX_WAIT_LO;
            end
            TX_WAIT_LO: begin
                if (!tx_busy) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Inter-byte timeout counter: cleared on each byte and outside a frame,
    // counts inside a frame and saturates at TIMEOUT.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_cnt <= '0;
        end else if (rx_valid || !w_in_frame) begin
            r_cnt <= '0;
        end else if (!w_timeout) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Frame data registers: opcode kind, bus address/data, response byte.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_is_write  <= 1'b0;
            r_reg_addr  <= 8'h00;
            r_reg_wdata <= 8'h00;
            r_tx_data   <= 8'h00;
        end else begin
            if (w_load_op)    r_is_write  <= w_op_write;
            if (w_load_addr)  r_reg_addr  <= rx_data;
            if (w_load_wdata) r_reg_wdata <= rx_data;
            if (w_load_tx)    r_tx_data   <= w_tx_val;
        end
    end

    assign tx_start  = w_tx_start;
    assign tx_data   = r_tx_data;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign reg_we    = w_reg_we;
    assign reg_re    = w_reg_re;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// tb_uart_reg_bridge: scoreboard bench for uart_reg_bridge.
// Expected bus strobes and response bytes are queued as frames are driven
// and compared as the DUT produces them.
module tb_uart_reg_bridge;

    localparam int unsigned TIMEOUT = 1000;
    localparam int          TX_LEN  = 20;

    typedef enum logic [1:0] {EV_WR, EV_RD, EV_TX} ev_kind_t;
    typedef struct packed {
        ev_kind_t   kind;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;

    logic       force_busy = 1'b0;
    int         busy_cnt = 0;
    logic [7:0] mem [256];
    ev_t        sb [$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         last_start_cyc = -1;
    int         release_cyc = 0;

    uart_reg_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .nRst     (nRst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_rdata(reg_rdata)
    );

    always #10 clk = ~clk;

    assign tx_busy = force_busy || (busy_cnt != 0);

    // Cycle counter, UART transmitter model and register bus model.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_start)          busy_cnt <= TX_LEN;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        if (reg_re) reg_rdata <= mem[reg_addr];
        if (reg_we) mem[reg_addr] <= reg_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_t kind, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        if (sb.size() == 0) begin
            check("unexpected_event", 32'(kind), 32'hFF);
        end else begin
            e = sb.pop_front();
            check("ev_kind", 32'(kind), 32'(e.kind));
            check("ev_addr", 32'(a), 32'(e.addr));
            check("ev_data", 32'(d), 32'(e.data));
        end
    endtask

    // Monitor: sample outputs on the falling edge and score them.
    always @(negedge clk) begin
        if (nRst) begin
            if (reg_we && reg_re) check("we_re_exclusive", 32'(1), 32'(0));
            if (reg_we) expect_ev(EV_WR, reg_addr, reg_wdata);
            if (reg_re) expect_ev(EV_RD, reg_addr, 8'h00);
            if (tx_start) begin
                last_start_cyc = cyc;
                check("start_while_busy", 32'(tx_busy), 32'(0));
                expect_ev(EV_TX, 8'h00, tx_data);
            end
        end
    end

    task automatic push(input ev_kind_t kind, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        push(EV_WR, a, d);
        push(EV_TX, 8'h00, 8'h4B);
        send_byte(8'h57);
        send_byte(a);
        send_byte(d);
    endtask

    task automatic do_read(input logic [7:0] a);
        push(EV_RD, a, 8'h00);
        push(EV_TX, 8'h00, mem[a]);
        send_byte(8'h52);
        send_byte(a);
    endtask

    // Wait until every queued event is seen and the transmitter is idle.
    task automatic wait_done(input string tag);
        int n;
        for (n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !tx_busy) break;
        end
        if (n >= 3000) begin
            check({tag, "_done_timeout"}, 32'(sb.size()), 32'(0));
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'hC3);
        mem[8'h34] = 8'h5C;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_tx_start", 32'(tx_start), 32'(0));
        check("rst_tx_data", 32'(tx_data), 32'(0));
        check("rst_reg_addr", 32'(reg_addr), 32'(0));
        check("rst_reg_wdata", 32'(reg_wdata), 32'(0));
        check("rst_reg_we", 32'(reg_we), 32'(0));
        check("rst_reg_re", 32'(reg_re), 32'(0));
        nRst = 1'b1;
        repeat (2) @(negedge clk);

        // Write, then read.
        do_write(8'h12, 8'hA5);
        wait_done("write");
        check("wr_addr_held", 32'(reg_addr), 32'h12);
        check("wr_data_held", 32'(reg_wdata), 32'hA5);
        do_read(8'h34);
        wait_done("read");
        do_read(8'h12);
        wait_done("read_back");

        // Bad opcode, then a good read.
        push(EV_TX, 8'h00, 8'h3F);
        send_byte(8'h00);
        wait_done("nak");
        do_read(8'h01);
        wait_done("read_after_nak");

        // Byte just before the timeout is still accepted.
        push(EV_WR, 8'h12, 8'h66);
        push(EV_TX, 8'h00, 8'h4B);
        send_byte(8'h57);
        send_byte(8'h12);
        repeat (990) @(negedge clk);
        send_byte(8'h66);
        wait_done("late_byte");

        // Timeout abandons the frame; 00 is then an opcode.
        send_byte(8'h57);
        send_byte(8'h12);
        repeat (1200) @(negedge clk);
        push(EV_TX, 8'h00, 8'h3F);
        send_byte(8'h00);
        wait_done("timeout");

        // Busy gating; bytes sent while waiting to transmit are dropped.
        force_busy = 1'b1;
        do_read(8'h07);
        send_byte(8'h57);
        send_byte(8'h33);
        send_byte(8'h44);
        repeat (480) @(negedge clk);
        @(posedge clk);
        #1;
        release_cyc = cyc;
        force_busy  = 1'b0;
        wait_done("busy");
        check("busy_start_cycle", 32'(last_start_cyc), 32'(release_cyc));
        check("dropped_no_write", 32'(mem[8'h33]), 32'(8'h33 ^ 8'hC3));

        // Reset mid-frame discards it.
        send_byte(8'h57);
        send_byte(8'hAA);
        @(negedge clk);
        nRst = 1'b0;
        #1;
        check("midrst_addr", 32'(reg_addr), 32'(0));
        check("midrst_tx_data", 32'(tx_data), 32'(0));
        check("midrst_we", 32'(reg_we), 32'(0));
        @(negedge clk);
        nRst = 1'b1;
        repeat (2) @(negedge clk);
        do_write(8'h01, 8'h02);
        wait_done("post_reset");

        // All 256 write values.
        for (int v = 0; v < 256; v++) begin
            do_write(8'(v) ^ 8'h5A, 8'(v));
            wait_done("sweep");
        end
        check("sweep_mem", 32'(mem[8'h5A]), 32'h00);
        check("sb_empty", 32'(sb.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
